md_unit_ctrl: RTL and testbench
===============================

// Module: md_unit_ctrl
// PURPOSE
//   Sequencer for the multiply/divide resource in the EX stage. It accepts mult/multu/div/divu/mthi/mtlo,
//   models the iterative latency with a busy counter and owns the HI/LO registers.
//   It raises a stall request to the hazard unit when the instruction in ID is a mult-type instruction
//   and the unit is busy or starting. An exception/eret flush in the same cycle cancels a pending start.
// PARAMETERS
//   MUL_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES  10  busy cycles for div/divu (>=1)
// PORTS
//   clk          in   1   clock
//   reset        in   1   reset, synchronous, active-high
//   op_valid     in   1   EX-stage instruction is an md op (qualifies md_op)
//   md_op        in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op
//   src_a        in   32  rs operand (forwarded)
//   src_b        in   32  rt operand (forwarded)
//   flush        in   1   exception/eret this cycle; blocks any accept of op_valid
//   id_md_instr  in   1   ID-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
//   hi           out  32  HI register
//   lo           out  32  LO register
//   busy         out  1   operation in flight
//   stall_req    out  1   hold ID/IF, bubble into EX (combinational)
// BEHAVIOUR
//   Reset: state IDLE, cnt=0, hi=0, lo=0, busy=0. Reset is honoured mid-operation; in-flight results are discarded.
//   accept = op_valid & ~flush & (state==IDLE).
//   Inputs while BUSY are ignored. The hazard unit guarantees none arrive; the bench checks this with an assertion.
//   Start ops (mult/multu/div/divu), on accept:
//     - compute the result from src_a/src_b and latch it into pend_hi/pend_lo;
//     - load cnt = MUL_CYCLES or DIV_CYCLES; state goes IDLE->BUSY.
//   Arithmetic:
//     - mult: 64-bit signed product, {HI,LO}. multu: unsigned.
//     - div: LO=quotient, HI=remainder, truncated toward zero (remainder takes sign of dividend). divu: unsigned.
//     - src_b==0 on div/divu: full latency, HI/LO left unchanged (pending write suppressed).
//   BUSY:
//     - cnt decrements each cycle;
//     - at the edge where cnt==1: hi/lo <= pending, busy falls, state goes BUSY->IDLE.
//   Timing: with accept at edge E0, busy=1 for exactly N cycles after E0, and new hi/lo are visible in the same cycle busy falls.
//   mthi/mtlo on accept: hi (resp. lo) <= src_a at that edge; no busy, no state change.
//   flush: suppresses accept only. It does not cancel an operation already BUSY (that op is older and committed).
//   stall_req = id_md_instr & (busy | (accept & md_op in {000..011})).
//     - Not raised for an accepted mthi/mtlo; EX->ID ordering makes that result visible next cycle.
//   Back-to-back: an ID md instruction stalls until busy=0, then issues. The unit re-accepts the cycle after busy falls.
// TESTING
//   1 mult src_a=FFFFFFFD src_b=00000005 -> busy high 5 cycles, then hi=FFFFFFFF lo=FFFFFFF1
//   2 divu 7/2 -> busy 10 cycles, hi=1 lo=3; div FFFFFFF9/2 -> hi=FFFFFFFF lo=FFFFFFFD
//   3 mthi 0x1234 then div src_b=0 -> busy 10 cycles, hi stays 0x1234, lo unchanged
//   4 multu with flush=1 same cycle -> busy stays 0, hi/lo unchanged, stall_req=0
//   5 mult accepted, id_md_instr=1 (mflo) -> stall_req=1 for cycles 0..5, then 0 with lo valid
//   6 reset asserted 3 cycles into div -> next cycle busy=0, hi=lo=0, later mtlo 5 gives lo=5

Source files
------------

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the EX stage: owns HI/LO, models iterative latency
// with a busy counter and requests ID/IF stalls while a result is outstanding.
module md_unit_ctrl #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   input  logic        id_md_instr,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall_req
);

   localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       pend_hi_q, pend_hi_d;
   logic [31:0]       pend_lo_q, pend_lo_d;
   logic              pend_we_q, pend_we_d;
   logic              busy_q, busy_d;

   logic              accept_s;
   logic              div_zero_s;
   logic signed [63:0] a_sx_s, b_sx_s, smul_s;
   logic [63:0]       umul_s;
   logic signed [31:0] sdivisor_s, squot_s, srem_s;
   logic [31:0]       udivisor_s, uquot_s, urem_s;

   assign accept_s   = op_valid & ~flush & (state_q == ST_IDLE);
   assign div_zero_s = (src_b == 32'd0);

   // Datapath; a zero divisor is replaced by one so the dividers never see it,
   // the write of that result is suppressed anyway.
   assign a_sx_s     = {{32{src_a[31]}}, src_a};
   assign b_sx_s     = {{32{src_b[31]}}, src_b};
   assign smul_s     = a_sx_s * b_sx_s;
   assign umul_s     = {32'd0, src_a} * {32'd0, src_b};
   assign sdivisor_s = div_zero_s ? 32'sd1 : $signed(src_b);
   assign udivisor_s = div_zero_s ? 32'd1 : src_b;
   assign squot_s    = $signed(src_a) / sdivisor_s;
   assign srem_s     = $signed(src_a) % sdivisor_s;
   assign uquot_s    = src_a / udivisor_s;
   assign urem_s     = src_a % udivisor_s;

   // Next-state logic for the sequencer and HI/LO.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_we_d = pend_we_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               case (md_op)
                  3'b000: begin
                     {pend_hi_d, pend_lo_d} = smul_s;
                     pend_we_d = 1'b1;
                     cnt_d     = CNT_W'(MUL_CYCLES);
                     state_d   = ST_BUSY;
                  end
                  3'b001: begin
                     {pend_hi_d, pend_lo_d} = umul_s;
                     pend_we_d = 1'b1;
                     cnt_d     = CNT_W'(MUL_CYCLES);
                     state_d   = ST_BUSY;
                  end
                  3'b010: begin
                     pend_hi_d = srem_s;
                     pend_lo_d = squot_s;
                     pend_we_d = ~div_zero_s;
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     state_d   = ST_BUSY;
                  end
                  3'b011: begin
                     pend_hi_d = urem_s;
                     pend_lo_d = uquot_s;
                     pend_we_d = ~div_zero_s;
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     state_d   = ST_BUSY;
                  end
                  3'b100:  hi_d = src_a;
                  3'b101:  lo_d = src_a;
                  default: state_d = ST_IDLE;
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_W'(0);
               if (pend_we_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end else begin
                  hi_d = hi_q;
               end
            end else begin
               state_d = ST_BUSY;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_W'(0);
         end
      endcase
      busy_d = (state_d == ST_BUSY);
   end

   // State registers; reset discards any in-flight result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= CNT_W'(0);
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_we_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_we_q <= pend_we_d;
         busy_q    <= busy_d;
      end
   end

   // The ID-stage md instruction must wait while a start is being accepted or running.
   assign stall_req = id_md_instr & (busy_q | (accept_s & ~md_op[2]));
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: expected HI/LO/latency queued at issue,
// compared by a monitor when busy falls; stall and direct-write cases checked inline.
module tb_md_unit_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [2:0]  md_op;
   logic [31:0] src_a, src_b;
   logic        flush;
   logic        id_md_instr;
   logic [31:0] hi, lo;
   logic        busy, stall_req;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;

   md_unit_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .md_op(md_op),
      .src_a(src_a), .src_b(src_b), .flush(flush), .id_md_instr(id_md_instr),
      .hi(hi), .lo(lo), .busy(busy), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: busy falling marks a completed op; compare against the queue head.
   logic busy_prev = 1'b0;
   int   busy_len  = 0;
   always @(negedge clk) begin
      if (busy === 1'b1) begin
         busy_len++;
      end else if (busy_prev) begin
         if (sb.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_hi"}, hi, e.hi);
            check({e.name, "_lo"}, lo, e.lo);
            check({e.name, "_busy_cycles"}, busy_len, e.cycles);
         end
         busy_len = 0;
      end
      busy_prev = (busy === 1'b1);
   end

   // No new md op may be presented while the unit is busy.
   always @(negedge clk) begin
      if (!reset) assert (!(busy && op_valid)) else $error("op_valid while busy");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin tick(); n++; end
      if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1; md_op = op; src_a = a; src_b = b;
   endtask

   task automatic clear_op();
      op_valid = 1'b0; md_op = 3'b111; flush = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      wait_idle();
      set_op(op, a, b);
      tick();
      clear_op();
   endtask

   function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input int c, input string n);
      exp_t e;
      e.hi = h; e.lo = l; e.cycles = c; e.name = n;
      return e;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; id_md_instr = 1'b0; src_a = 32'd0; src_b = 32'd0;
      clear_op();
      repeat (3) tick();
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_stall", {31'd0, stall_req}, 32'd0);
      reset = 1'b0;
      tick();

      // 1: signed multiply of -3 by 5
      sb.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFF1, 5, "mult"));
      issue(3'b000, 32'hFFFFFFFD, 32'h00000005);

      // 2: divu then back-to-back signed div
      sb.push_back(mk(32'h00000001, 32'h00000003, 10, "divu"));
      issue(3'b011, 32'd7, 32'd2);
      sb.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg"));
      issue(3'b010, 32'hFFFFFFF9, 32'd2);

      // 3: mthi, then divide by zero leaves HI/LO alone
      wait_idle();
      id_md_instr = 1'b1;
      set_op(3'b100, 32'h00001234, 32'd0);
      @(negedge clk);
      check("mthi_no_stall", {31'd0, stall_req}, 32'd0);
      tick();
      clear_op();
      id_md_instr = 1'b0;
      @(negedge clk);
      check("mthi_hi", hi, 32'h00001234);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      tick();
      sb.push_back(mk(32'h00001234, 32'hFFFFFFFD, 10, "div_zero"));
      issue(3'b010, 32'd99, 32'd0);

      // 4: flush blocks a multu start
      wait_idle();
      id_md_instr = 1'b1;
      set_op(3'b001, 32'd2, 32'd3);
      flush = 1'b1;
      @(negedge clk);
      check("flush_stall", {31'd0, stall_req}, 32'd0);
      tick();
      clear_op();
      id_md_instr = 1'b0;
      @(negedge clk);
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_hi", hi, 32'h00001234);
      check("flush_lo", lo, 32'hFFFFFFFD);
      tick();

      // unsigned multiply of full-scale operands
      sb.push_back(mk(32'hFFFFFFFE, 32'h00000001, 5, "multu"));
      issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);

      // 5: mflo in ID stalls through the whole mult
      wait_idle();
      sb.push_back(mk(32'h00000000, 32'h0000000C, 5, "mult_stall"));
      set_op(3'b000, 32'd3, 32'd4);
      id_md_instr = 1'b1;
      @(negedge clk);
      check("stall_c0", {31'd0, stall_req}, 32'd1);
      tick();
      clear_op();
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("stall_c%0d", k), {31'd0, stall_req}, 32'd1);
      end
      @(negedge clk);
      check("stall_released", {31'd0, stall_req}, 32'd0);
      check("stall_lo_valid", lo, 32'h0000000C);
      tick();
      id_md_instr = 1'b0;

      // 6: reset three cycles into a div discards it
      sb.push_back(mk(32'd0, 32'd0, 3, "div_reset"));
      issue(3'b010, 32'd100, 32'd7);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_hi", hi, 32'd0);
      check("rst_mid_lo", lo, 32'd0);
      tick();
      issue(3'b101, 32'd5, 32'd0);
      @(negedge clk);
      check("mtlo_lo", lo, 32'd5);
      check("mtlo_hi", hi, 32'd0);
      check("mtlo_busy", {31'd0, busy}, 32'd0);

      repeat (3) tick();
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
